// File: rtl/gtp_blkrcv_pkg.sv
// Shared constants, FSM state encoding and FIFO word layout for the GTP block receiver.
// Optional statistics counters are enabled with GTP_BLKRCV_STAT_EN.
package gtp_blkrcv_pkg;

  localparam int HDR_BIT = 15;
  localparam int CHN_MSB = 14;
  localparam int CHN_LSB = 9;
  localparam int LEN_MSB = 8;
  localparam logic [15:0] TRUNC_WORD = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } blk_state_e;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } fifo_word_t;

  function automatic fifo_word_t mk_word(input logic [15:0] data, input logic sop, input logic eop);
    fifo_word_t w;
    w.sop  = sop;
    w.eop  = eop;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/gtp_blkrcv_fifo.sv
// First-word fall-through block FIFO, 18 bits wide, accepting up to two writes per cycle.
// Storage is split into even/odd banks so each bank sees at most one write and one read.
module blkrcv_fifo
  import gtp_blkrcv_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr0_en,
  input  fifo_word_t  wr0_word,
  input  logic        wr1_en,
  input  fifo_word_t  wr1_word,
  input  logic        rd_ready,
  output logic        rd_valid,
  output fifo_word_t  rd_word,
  output logic [AW:0] free
);

  localparam int BAW    = AW - 1;
  localparam int BDEPTH = 2 ** BAW;
  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_wr_ptr1;
  logic [AW:0]   r_count;
  logic          r_valid;
  logic          r_sel;
  logic          w_load;
  logic [1:0]    w_nwr;
  fifo_word_t    w_bank_q [2];

  assign w_wr_ptr1 = r_wr_ptr + 1'b1;
  assign w_nwr     = {1'b0, wr0_en} + {1'b0, wr1_en};
  // Refill the output register whenever it is empty or being consumed.
  assign w_load    = (r_count != '0) && (!r_valid || rd_ready);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      fifo_word_t     r_mem [BDEPTH];
      fifo_word_t     r_q;
      logic           w_we;
      logic [BAW-1:0] w_waddr;
      fifo_word_t     w_wdata;

      always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_ptr[AW-1:1];
        w_wdata = wr0_word;
        if (wr0_en && (r_wr_ptr[0] == 1'(gi))) begin
          w_we = 1'b1;
        end else if (wr1_en && (w_wr_ptr1[0] == 1'(gi))) begin
          w_we    = 1'b1;
          w_waddr = w_wr_ptr1[AW-1:1];
          w_wdata = wr1_word;
        end
      end

      always_ff @(posedge clk) begin
        if (w_we) begin
          r_mem[w_waddr] <= w_wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_load) begin
          r_q <= r_mem[r_rd_ptr[AW-1:1]];
        end
      end

      assign w_bank_q[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_sel    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_nwr);
      r_rd_ptr <= r_rd_ptr + AW'(w_load);
      r_count  <= r_count + (AW + 1)'(w_nwr) - (AW + 1)'(w_load);
      if (w_load) begin
        r_valid <= 1'b1;
        r_sel   <= r_rd_ptr[0];
      end else if (rd_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rd_valid = r_valid;
  assign rd_word  = w_bank_q[r_sel];
  assign free     = DEPTH - r_count;

endmodule

// File: rtl/gtp_blkrcv.sv
// GTP lane block receiver: frames header/payload words into sop/eop blocks in a FIFO.
// Define GTP_BLKRCV_STAT_EN to add blk_cnt/short_cnt/ovf_cnt statistics outputs.
module gtp_blkrcv
  import gtp_blkrcv_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int MAXLEN  = 511
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        charisk_i,
  output logic [15:0] dout,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        err_short,
  output logic        err_orphan,
  output logic        err_ovf,
  output logic        err_len
`ifdef GTP_BLKRCV_STAT_EN
  ,
  output logic [15:0] blk_cnt,
  output logic [7:0]  short_cnt,
  output logic [7:0]  ovf_cnt
`endif
);

  logic [15:0]      r_data;
  logic             r_isk;
  logic             r_in_vld;
  blk_state_e       r_state;
  blk_state_e       w_state_next;
  logic [LEN_MSB:0] r_cnt;
  logic [LEN_MSB:0] w_cnt_next;

  logic             w_is_hdr;
  logic             w_is_pay;
  logic             w_is_com;
  logic [LEN_MSB:0] w_len;
  logic             w_len_bad;
  logic             w_room;
  logic [FIFO_AW:0] w_free;
  logic [FIFO_AW:0] w_avail;
  logic [FIFO_AW:0] w_need;

  logic             w_wr0_en;
  logic             w_wr1_en;
  fifo_word_t       w_wr0_word;
  fifo_word_t       w_wr1_word;
  fifo_word_t       w_rd_word;
  logic             w_short;
  logic             w_orphan;
  logic             w_ovf;
  logic             w_lenerr;
  logic             r_err_short;
  logic             r_err_orphan;
  logic             r_err_ovf;
  logic             r_err_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_isk    <= 1'b0;
      r_in_vld <= 1'b0;
    end else begin
      r_data   <= data_i;
      r_isk    <= charisk_i;
      r_in_vld <= 1'b1;
    end
  end

  assign w_is_com  = r_in_vld && r_isk;
  assign w_is_hdr  = r_in_vld && !r_isk && r_data[HDR_BIT];
  assign w_is_pay  = r_in_vld && !r_isk && !r_data[HDR_BIT];
  assign w_len     = r_data[LEN_MSB:0];
  assign w_len_bad = int'(w_len) > MAXLEN;

  // A header that truncates a block spends one entry of the old reservation on the terminator.
  assign w_avail = w_free - (FIFO_AW + 1)'(r_state == RECV);
  assign w_need  = (FIFO_AW + 1)'(w_len) + (FIFO_AW + 1)'(2);
  assign w_room  = w_avail >= w_need;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_wr0_en     = 1'b0;
    w_wr0_word   = '0;
    w_wr1_en     = 1'b0;
    w_wr1_word   = '0;
    w_short      = 1'b0;
    w_orphan     = 1'b0;
    w_ovf        = 1'b0;
    w_lenerr     = 1'b0;

    if (w_is_hdr) begin
      if (r_state == RECV) begin
        w_short    = 1'b1;
        w_wr0_en   = 1'b1;
        w_wr0_word = mk_word(TRUNC_WORD, 1'b0, 1'b1);
      end
      if (w_len_bad) begin
        w_lenerr     = 1'b1;
        w_state_next = DROP;
      end else if (!w_room) begin
        w_ovf        = 1'b1;
        w_state_next = DROP;
      end else begin
        // The header goes in the second write slot when the terminator occupies the first.
        if (r_state == RECV) begin
          w_wr1_en   = 1'b1;
          w_wr1_word = mk_word(r_data, 1'b1, w_len == '0);
        end else begin
          w_wr0_en   = 1'b1;
          w_wr0_word = mk_word(r_data, 1'b1, w_len == '0);
        end
        w_cnt_next   = w_len;
        w_state_next = (w_len == '0) ? IDLE : RECV;
      end
    end else if (w_is_com) begin
      if (r_state == RECV) begin
        w_short    = 1'b1;
        w_wr0_en   = 1'b1;
        w_wr0_word = mk_word(TRUNC_WORD, 1'b0, 1'b1);
      end
      w_state_next = IDLE;
    end else if (w_is_pay) begin
      unique case (r_state)
        IDLE: w_orphan = 1'b1;
        RECV: begin
          w_wr0_en   = 1'b1;
          w_wr0_word = mk_word(r_data, 1'b0, r_cnt == 9'd1);
          w_cnt_next = r_cnt - 9'd1;
          if (r_cnt == 9'd1) begin
            w_state_next = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_short  <= 1'b0;
      r_err_orphan <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_err_short  <= w_short;
      r_err_orphan <= w_orphan;
      r_err_ovf    <= w_ovf;
      r_err_len    <= w_lenerr;
    end
  end

  blkrcv_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (w_wr0_en),
    .wr0_word (w_wr0_word),
    .wr1_en   (w_wr1_en),
    .wr1_word (w_wr1_word),
    .rd_ready (dout_ready),
    .rd_valid (dout_valid),
    .rd_word  (w_rd_word),
    .free     (w_free)
  );

  assign dout       = w_rd_word.data;
  assign dout_sop   = w_rd_word.sop;
  assign dout_eop   = w_rd_word.eop;
  assign err_short  = r_err_short;
  assign err_orphan = r_err_orphan;
  assign err_ovf    = r_err_ovf;
  assign err_len    = r_err_len;

`ifdef GTP_BLKRCV_STAT_EN
  logic        w_blk_done;
  logic [15:0] r_blk_cnt;
  logic [7:0]  r_short_cnt;
  logic [7:0]  r_ovf_cnt;

  // Only untruncated blocks count as complete; a truncation always occupies write slot 0.
  assign w_blk_done = (w_wr0_en && w_wr0_word.eop && !w_short) || (w_wr1_en && w_wr1_word.eop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk_cnt   <= '0;
      r_short_cnt <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_blk_done) begin
        r_blk_cnt <= r_blk_cnt + 16'd1;
      end
      if (w_short && (r_short_cnt != 8'hFF)) begin
        r_short_cnt <= r_short_cnt + 8'd1;
      end
      if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

  assign blk_cnt   = r_blk_cnt;
  assign short_cnt = r_short_cnt;
  assign ovf_cnt   = r_ovf_cnt;
`endif

endmodule
